// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target endpoint.
package spi_pkg;

    // Framing FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_DATA    = 2'd2,
        ST_WAIT_CS = 2'd3
    } spi_state_t;

    // Mode 0: SCLK idles low, data sampled on the rising edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int DEF_CMD_W  = 8;
    localparam int DEF_DATA_W = 16;

    // The command MSB carries the read/write flag
    function automatic int rd_bit_idx(input int cmd_w);
        return cmd_w - 1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one SPI pin with rise/fall event pulses.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   prev_p;

    // Synchronizer chain plus a registered copy of its output for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= {SYNC_STAGES{RST_VAL}};
            prev_p <= RST_VAL;
        end else begin
            sync_p[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
            prev_p <= sync_p[SYNC_STAGES-1];
        end
    end

    assign dout = sync_p[SYNC_STAGES-1];
    assign rise = dout & ~prev_p;
    assign fall = ~dout & prev_p;

endmodule

// File: rtl/spi_slave_controller.sv
// Oversampling SPI target: 8-bit command + 16-bit data frames, mode 0, MSB first.
module spi_slave_controller
    import spi_pkg::*;
#(
    parameter int CMD_W       = DEF_CMD_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    spi_clk_i,
    input  logic                    spi_cs_n_i,
    input  logic                    spi_sdi_i,
    output logic                    spi_sdo_o,
    output logic                    spi_sdo_oe_o,
    output logic [CMD_W-2+DATA_W:0] stream_data_rx_o,
    output logic                    stream_data_rx_vld_o,
    input  logic                    stream_data_rx_rdy_i,
    input  logic [DATA_W-1:0]       stream_data_tx_i,
    input  logic                    stream_data_tx_vld_i,
    output logic                    stream_data_tx_rdy_o,
    output logic [CMD_W-2:0]        cmd_addr_o,
    output logic                    eot_o,
    output logic                    ovf_o,
    output logic                    udr_o
);

    localparam int RD_BIT = rd_bit_idx(CMD_W);
    localparam int CNT_W  = $clog2(((CMD_W > DATA_W) ? CMD_W : DATA_W) + 1);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise_unused, cs_fall_unused;
    logic sdi_sync, sdi_rise_unused, sdi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk_i), .rst_n(rst_n_i), .din(spi_clk_i),
        .dout(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk_i), .rst_n(rst_n_i), .din(spi_cs_n_i),
        .dout(cs_sync), .rise(cs_rise_unused), .fall(cs_fall_unused)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk_i), .rst_n(rst_n_i), .din(spi_sdi_i),
        .dout(sdi_sync), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

    // Sampling edge and shifting edge for the configured SPI mode
    logic sample_evt, shift_evt;
    assign sample_evt = (SPI_CPOL == SPI_CPHA) ? sclk_rise : sclk_fall;
    assign shift_evt  = (SPI_CPOL == SPI_CPHA) ? sclk_fall : sclk_rise;

    spi_state_t             state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [CMD_W-2:0]       cmd_sr_q;
    logic [DATA_W-2:0]      rx_sr_q;
    logic [DATA_W-1:0]      tx_sr_q;
    logic                   is_rd_q;
    logic [SYNC_STAGES:0]   flush_q;
    logic                   armed_q;
    logic                   cmd_bit, cmd_done, data_bit, data_done, tx_shift;
    logic [CMD_W-1:0]       cmd_word;
    logic [DATA_W-1:0]      rx_word;

    // Words including the bit being sampled this cycle
    assign cmd_word = {cmd_sr_q, sdi_sync};
    assign rx_word  = {rx_sr_q, sdi_sync};

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state and per-cycle framing strobes; CS high aborts any active frame
    always_comb begin
        state_d   = state_q;
        cmd_bit   = 1'b0;
        cmd_done  = 1'b0;
        data_bit  = 1'b0;
        data_done = 1'b0;
        tx_shift  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (armed_q && !cs_sync) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (cs_sync) begin
                    state_d = ST_IDLE;
                end else if (sample_evt) begin
                    cmd_bit = 1'b1;
                    if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
                        cmd_done = 1'b1;
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (cs_sync) begin
                    state_d = ST_IDLE;
                end else begin
                    if (sample_evt) begin
                        data_bit = 1'b1;
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            data_done = 1'b1;
                            state_d   = ST_WAIT_CS;
                        end
                    end
                    if (shift_evt && bit_cnt_q != '0 && is_rd_q) tx_shift = 1'b1;
                end
            end
            ST_WAIT_CS: begin
                if (cs_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Only accept a CS fall once CS has been seen high after reset, so a frame
    // already running on the bus when reset releases is ignored.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            flush_q <= '0;
            armed_q <= 1'b0;
        end else begin
            flush_q <= {flush_q[SYNC_STAGES-1:0], 1'b1};
            if (flush_q[SYNC_STAGES] && cs_sync) armed_q <= 1'b1;
        end
    end

    // Shift registers, command capture, RX holding register and event pulses
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt_q            <= '0;
            cmd_sr_q             <= '0;
            rx_sr_q              <= '0;
            tx_sr_q              <= '0;
            is_rd_q              <= 1'b0;
            cmd_addr_o           <= '0;
            stream_data_rx_o     <= '0;
            stream_data_rx_vld_o <= 1'b0;
            stream_data_tx_rdy_o <= 1'b0;
            eot_o                <= 1'b0;
            ovf_o                <= 1'b0;
            udr_o                <= 1'b0;
        end else begin
            stream_data_tx_rdy_o <= 1'b0;
            eot_o                <= data_done;
            ovf_o                <= 1'b0;
            udr_o                <= 1'b0;

            if (state_d != state_q)      bit_cnt_q <= '0;
            else if (cmd_bit || data_bit) bit_cnt_q <= bit_cnt_q + 1'b1;

            if (cmd_bit)  cmd_sr_q <= cmd_word[CMD_W-2:0];
            if (data_bit) rx_sr_q  <= rx_word[DATA_W-2:0];

            if (cmd_done) begin
                cmd_addr_o <= cmd_word[CMD_W-2:0];
                is_rd_q    <= cmd_word[RD_BIT];
                if (cmd_word[RD_BIT]) begin
                    if (stream_data_tx_vld_i) begin
                        tx_sr_q              <= stream_data_tx_i;
                        stream_data_tx_rdy_o <= 1'b1;
                    end else begin
                        tx_sr_q <= '1;
                        udr_o   <= 1'b1;
                    end
                end
            end else if (tx_shift) begin
                tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
            end

            if (data_done && !is_rd_q) begin
                if (stream_data_rx_vld_o && !stream_data_rx_rdy_i) begin
                    ovf_o <= 1'b1;
                end else begin
                    stream_data_rx_o     <= {cmd_addr_o, rx_word};
                    stream_data_rx_vld_o <= 1'b1;
                end
            end else if (stream_data_rx_vld_o && stream_data_rx_rdy_i) begin
                stream_data_rx_vld_o <= 1'b0;
            end
        end
    end

    assign spi_sdo_o    = tx_sr_q[DATA_W-1];
    assign spi_sdo_oe_o = (state_q != ST_IDLE) && !cs_sync;

endmodule

// File: tb/tb_spi_slave_controller.sv
// Directed + random bench for spi_slave_controller with an RX scoreboard.
module tb_spi_slave_controller;
    import spi_pkg::*;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk, cs_n, sdi;
    logic        sdo, sdo_oe;
    logic [22:0] rx_data;
    logic        rx_vld;
    logic        rx_rdy = 1'b0;
    logic [15:0] tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic [6:0]  cmd_addr;
    logic        eot, ovf, udr;

    int total = 0;
    int bad   = 0;
    int eot_cnt = 0, ovf_cnt = 0, udr_cnt = 0, txr_cnt = 0, vld_cyc = 0;
    int rdy_mode = 0;
    logic [22:0] got_q[$];
    logic [22:0] exp_q[$];

    spi_slave_controller dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .spi_clk_i(sclk), .spi_cs_n_i(cs_n), .spi_sdi_i(sdi),
        .spi_sdo_o(sdo), .spi_sdo_oe_o(sdo_oe),
        .stream_data_rx_o(rx_data), .stream_data_rx_vld_o(rx_vld),
        .stream_data_rx_rdy_i(rx_rdy),
        .stream_data_tx_i(tx_data), .stream_data_tx_vld_i(tx_vld),
        .stream_data_tx_rdy_o(tx_rdy),
        .cmd_addr_o(cmd_addr), .eot_o(eot), .ovf_o(ovf), .udr_o(udr)
    );

    always #5 clk = ~clk;

    // RX consumer ready: held low, held high, or random back-pressure
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rx_rdy = 1'b0;
            1:       rx_rdy = 1'b1;
            default: rx_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: counts pulses and collects accepted RX words
    always @(negedge clk) begin
        if (eot)    eot_cnt++;
        if (ovf)    ovf_cnt++;
        if (udr)    udr_cnt++;
        if (tx_rdy) txr_cnt++;
        if (rx_vld) vld_cyc++;
        if (rx_vld && rx_rdy) got_q.push_back(rx_data);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare collected RX words against the scoreboard, in order
    task automatic check_rx(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_word"}, {9'd0, got_q.pop_front()}, {9'd0, exp_q.pop_front()});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Mode-0 master: nrise SCLK rises, optional CS release at the end
    task automatic spi_xfer(input logic [7:0] cmd, input logic [15:0] data,
                            input int nrise, input bit end_cs, output logic [15:0] miso);
        logic [23:0] word;
        word = {cmd, data};
        miso = '0;
        cs_n = 1'b0;
        for (int i = 0; i < nrise; i++) begin
            sdi = word[23-i];
            wait_clk(HALF);
            sclk = 1'b1;
            if (i >= 8) miso[23-i] = sdo;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        if (end_cs) begin
            cs_n = 1'b1;
            wait_clk(2 * HALF);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sdo"},    {31'd0, sdo},    32'd0);
        check({tag, "_oe"},     {31'd0, sdo_oe}, 32'd0);
        check({tag, "_rxd"},    {9'd0, rx_data}, 32'd0);
        check({tag, "_vld"},    {31'd0, rx_vld}, 32'd0);
        check({tag, "_txrdy"},  {31'd0, tx_rdy}, 32'd0);
        check({tag, "_addr"},   {25'd0, cmd_addr}, 32'd0);
        check({tag, "_pulses"}, {29'd0, eot, ovf, udr}, 32'd0);
        check({tag, "_state"},  {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    endtask

    initial begin
        logic [15:0] miso;
        logic [15:0] rdat;
        logic [6:0]  raddr;
        int e0, o0, u0, t0, v0;

        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; sdi = 1'b0;
        tx_data = '0; tx_vld = 1'b0; rdy_mode = 1;
        wait_clk(5);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        wait_clk(10);

        // Write frame 0x10 / 0xA001
        e0 = eot_cnt; v0 = vld_cyc;
        exp_q.push_back({7'h10, 16'hA001});
        spi_xfer(8'h10, 16'hA001, 24, 1'b1, miso);
        wait_clk(4);
        check_rx("wr1");
        check("wr1_eot",   eot_cnt - e0, 1);
        check("wr1_vldcyc", vld_cyc - v0, 1);
        check("wr1_sdo",   {31'd0, sdo}, 32'd0);
        check("wr1_addr",  {25'd0, cmd_addr}, 32'h10);

        // Read frame 0xB0 with a TX word available
        t0 = txr_cnt; u0 = udr_cnt;
        tx_data = 16'h5A3C; tx_vld = 1'b1;
        spi_xfer(8'hB0, 16'h0000, 24, 1'b1, miso);
        tx_vld = 1'b0;
        wait_clk(4);
        check("rd1_miso",  {16'd0, miso}, 32'h5A3C);
        check("rd1_txrdy", txr_cnt - t0, 1);
        check("rd1_udr",   udr_cnt - u0, 0);
        check("rd1_addr",  {25'd0, cmd_addr}, 32'h30);
        check_rx("rd1_norx");

        // Read frame with no TX word: underrun
        t0 = txr_cnt; u0 = udr_cnt;
        spi_xfer(8'h85, 16'h0000, 24, 1'b1, miso);
        wait_clk(4);
        check("rd2_miso",  {16'd0, miso}, 32'hFFFF);
        check("rd2_udr",   udr_cnt - u0, 1);
        check("rd2_txrdy", txr_cnt - t0, 0);

        // Two writes with no consumer: second overflows
        rdy_mode = 0;
        wait_clk(3);
        o0 = ovf_cnt;
        spi_xfer(8'h01, 16'h1111, 24, 1'b1, miso);
        wait_clk(2);
        check("ovf_first", ovf_cnt - o0, 0);
        check("ovf_vld1",  {31'd0, rx_vld}, 32'd1);
        spi_xfer(8'h01, 16'h2222, 24, 1'b1, miso);
        wait_clk(2);
        check("ovf_second", ovf_cnt - o0, 1);
        check("ovf_hold",   {9'd0, rx_data}, {9'd0, 7'h01, 16'h1111});
        rdy_mode = 1;
        exp_q.push_back({7'h01, 16'h1111});
        wait_clk(6);
        check_rx("ovf_drain");
        check("ovf_vld0", {31'd0, rx_vld}, 32'd0);

        // Abort after 12 rises, then a full frame
        e0 = eot_cnt;
        spi_xfer(8'h22, 16'h4321, 12, 1'b1, miso);
        wait_clk(2);
        check("abort_eot",   eot_cnt - e0, 0);
        check("abort_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        check_rx("abort_norx");
        exp_q.push_back({7'h00, 16'hBEEF});
        spi_xfer(8'h00, 16'hBEEF, 24, 1'b1, miso);
        wait_clk(4);
        check_rx("after_abort");

        // Reset in the middle of the data phase
        spi_xfer(8'h33, 16'hCAFE, 14, 1'b0, miso);
        rst_n = 1'b0;
        wait_clk(3);
        check_idle_outputs("midrst");
        rst_n = 1'b1;
        e0 = eot_cnt;
        for (int i = 0; i < 10; i++) begin
            wait_clk(HALF); sclk = 1'b1;
            wait_clk(HALF); sclk = 1'b0;
        end
        wait_clk(HALF);
        check("midrst_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        cs_n = 1'b1;
        wait_clk(2 * HALF);
        check("midrst_eot", eot_cnt - e0, 0);
        check_rx("midrst_norx");
        exp_q.push_back({7'h12, 16'h3456});
        spi_xfer(8'h12, 16'h3456, 24, 1'b1, miso);
        wait_clk(4);
        check_rx("midrst_next");

        // Random writes with random back-pressure
        rdy_mode = 2;
        o0 = ovf_cnt;
        for (int n = 0; n < 20; n++) begin
            int ob;
            raddr = 7'($urandom);
            rdat  = 16'($urandom);
            ob = ovf_cnt;
            spi_xfer({1'b0, raddr}, rdat, 24, 1'b1, miso);
            wait_clk(1);
            if (ovf_cnt == ob) exp_q.push_back({raddr, rdat});
        end
        rdy_mode = 1;
        wait_clk(6);
        check("rnd_accounted", got_q.size() + (ovf_cnt - o0), 20);
        check_rx("rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
